// File: rtl/ex_wb_stage_if.sv
// ex_wb_stage_if: issue bundle into the execute stage and the
// register file write-back bundle out of it.
//   master: drives in_* and observes stall and wb_*.
//   slave : the stage itself; consumes in_* and drives stall and wb_*.
//   in_rs1/in_rs2 exist only when EX_BYPASS_EN is defined.
interface ex_wb_stage_if #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5
);
    logic             in_valid;
    logic [3:0]       in_op;
    logic [ASIZE-1:0] in_rd;
    logic [DSIZE-1:0] in_a;
    logic [DSIZE-1:0] in_b;
`ifdef EX_BYPASS_EN
    logic [ASIZE-1:0] in_rs1;
    logic [ASIZE-1:0] in_rs2;
`endif
    logic             stall;
    logic             wb_wen;
    logic [ASIZE-1:0] wb_waddr;
    logic [DSIZE-1:0] wb_wdata;

    modport master (
`ifdef EX_BYPASS_EN
        output in_rs1,
        output in_rs2,
`endif
        output in_valid,
        output in_op,
        output in_rd,
        output in_a,
        output in_b,
        input  stall,
        input  wb_wen,
        input  wb_waddr,
        input  wb_wdata
    );

    modport slave (
`ifdef EX_BYPASS_EN
        input  in_rs1,
        input  in_rs2,
`endif
        input  in_valid,
        input  in_op,
        input  in_rd,
        input  in_a,
        input  in_b,
        output stall,
        output wb_wen,
        output wb_waddr,
        output wb_wdata
    );
endinterface

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute stage; single-cycle ALU ops plus shift-add MUL.
// Ports: clk, rst (sync, active-high), bus (ex_wb_stage_if.slave).
// Optional: EX_BYPASS_EN forwards the held write-back value to operands.
module ex_wb_stage #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5,
    parameter int SHW   = 5
) (
    input logic          clk,
    input logic          rst,
    ex_wb_stage_if.slave bus
);
    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    localparam logic [SHW-1:0] LAST = SHW'(DSIZE - 1);

    state_t           state;
    logic             stall_q;
    logic             wen_q;
    logic [ASIZE-1:0] waddr_q;
    logic [DSIZE-1:0] wdata_q;

    logic [DSIZE-1:0] mcand;
    logic [DSIZE-1:0] mplier;
    logic [DSIZE-1:0] acc;
    logic [ASIZE-1:0] mrd;
    logic [SHW-1:0]   cnt;

    logic [DSIZE-1:0] op_a;
    logic [DSIZE-1:0] op_b;
    logic [DSIZE-1:0] alu_res;
    logic [DSIZE-1:0] acc_nxt;
    logic             is_wr;
    logic             is_mul;

    assign bus.stall    = stall_q;
    assign bus.wb_wen   = wen_q;
    assign bus.wb_waddr = waddr_q;
    assign bus.wb_wdata = wdata_q;

`ifdef EX_BYPASS_EN
    // Back-to-back dependence: the producer's value is still in wdata_q.
    assign op_a = (wen_q && waddr_q == bus.in_rs1) ? wdata_q : bus.in_a;
    assign op_b = (wen_q && waddr_q == bus.in_rs2) ? wdata_q : bus.in_b;
`else
    assign op_a = bus.in_a;
    assign op_b = bus.in_b;
`endif

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        alu_res = '0;
        is_wr   = 1'b1;
        is_mul  = 1'b0;
        case (bus.in_op)
            4'd0: alu_res = op_a + op_b;
            4'd1: alu_res = op_a - op_b;
            4'd2: alu_res = op_a & op_b;
            4'd3: alu_res = op_a | op_b;
            4'd4: alu_res = op_a ^ op_b;
            4'd5: alu_res = op_a << op_b[SHW-1:0];
            4'd6: alu_res = op_a >> op_b[SHW-1:0];
            4'd7: alu_res = {{(DSIZE-1){1'b0}},
                             $signed(op_a) < $signed(op_b)};
            4'd8: begin
                is_wr  = 1'b0;
                is_mul = 1'b1;
            end
            default: is_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            stall_q <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            mrd     <= '0;
            cnt     <= '0;
        end else begin
            wen_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && is_mul) begin
                        mcand   <= op_a;
                        mplier  <= op_b;
                        mrd     <= bus.in_rd;
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= MUL_BUSY;
                        stall_q <= 1'b1;
                    end else if (bus.in_valid && is_wr) begin
                        wen_q   <= 1'b1;
                        waddr_q <= bus.in_rd;
                        wdata_q <= alu_res;
                    end
                end
                MUL_BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state   <= IDLE;
                        stall_q <= 1'b0;
                        wen_q   <= 1'b1;
                        waddr_q <= mrd;
                        wdata_q <= acc_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage: directed and random stimulus for ex_wb_stage against
// a cycle-level behavioural model.
module tb_ex_wb_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   started = 1'b0;

    always #5 clk = ~clk;

    ex_wb_stage_if #(.DSIZE(32), .ASIZE(5)) bus ();

    ex_wb_stage #(.DSIZE(32), .ASIZE(5), .SHW(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Model state: what the outputs must be after the latest edge.
    logic        m_stall = 1'b0;
    logic        m_wen   = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    int          m_left  = 0;
    logic [4:0]  m_rd    = '0;
    logic [31:0] m_res   = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] a, b, r;
        started = 1'b1;
        a = bus.in_a;
        b = bus.in_b;
`ifdef EX_BYPASS_EN
        if (m_wen && m_waddr == bus.in_rs1) a = m_wdata;
        if (m_wen && m_waddr == bus.in_rs2) b = m_wdata;
`endif
        if (rst) begin
            m_stall = 1'b0;
            m_wen   = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_left  = 0;
        end else if (m_stall) begin
            m_wen  = 1'b0;
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_stall = 1'b0;
                m_wen   = 1'b1;
                m_waddr = m_rd;
                m_wdata = m_res;
            end
        end else if (bus.in_valid) begin
            m_wen = 1'b1;
            case (bus.in_op)
                4'd0: r = a + b;
                4'd1: r = a - b;
                4'd2: r = a & b;
                4'd3: r = a | b;
                4'd4: r = a ^ b;
                4'd5: r = a << (b % 32);
                4'd6: r = a >> (b % 32);
                4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: begin
                    r = m_wdata;
                    m_wen = 1'b0;
                end
            endcase
            if (bus.in_op == 4'd8) begin
                m_res   = a * b;
                m_rd    = bus.in_rd;
                m_left  = 32;
                m_stall = 1'b1;
            end
            if (m_wen) begin
                m_waddr = bus.in_rd;
                m_wdata = r;
            end
        end else begin
            m_wen = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("stall", 32'(bus.stall), 32'(m_stall));
            chk("wen", 32'(bus.wb_wen), 32'(m_wen));
            chk("waddr", 32'(bus.wb_waddr), 32'(m_waddr));
            chk("wdata", bus.wb_wdata, m_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    initial begin
        int n;
        int wcnt;
        drive(1'b0, 4'd9, 5'd0, 32'd0, 32'd0);
`ifdef EX_BYPASS_EN
        bus.in_rs1 = '0;
        bus.in_rs2 = '0;
`endif
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_stall", 32'(bus.stall), 32'd0);
            chk("idle_wen", 32'(bus.wb_wen), 32'd0);
            chk("idle_wdata", bus.wb_wdata, 32'd0);
        end

        drive(1'b1, 4'd0, 5'd4, 32'd5, 32'd2);
        tick();
        chk("add_wen", 32'(bus.wb_wen), 32'd1);
        chk("add_waddr", 32'(bus.wb_waddr), 32'd4);
        chk("add_wdata", bus.wb_wdata, 32'd7);
        chk("model_add", m_wdata, 32'd7);
        drive(1'b1, 4'd1, 5'd6, 32'd2, 32'd5);
        tick();
        chk("sub_wdata", bus.wb_wdata, 32'hFFFF_FFFD);
        drive(1'b1, 4'd7, 5'd7, 32'hFFFF_FFFD, 32'd2);
        tick();
        chk("slt_wdata", bus.wb_wdata, 32'd1);
        drive(1'b1, 4'd5, 5'd1, 32'd1, 32'h21);
        tick();
        chk("sll_wdata", bus.wb_wdata, 32'd2);
        drive(1'b1, 4'd6, 5'd2, 32'h8000_0000, 32'd31);
        tick();
        chk("srl_wdata", bus.wb_wdata, 32'd1);
        drive(1'b1, 4'd9, 5'd9, 32'd3, 32'd3);
        tick();
        chk("nop_wen", 32'(bus.wb_wen), 32'd0);
        chk("nop_hold", bus.wb_wdata, 32'd1);

        // MUL with an ADD held behind it
        drive(1'b1, 4'd8, 5'd8, 32'd5, 32'd7);
        tick();
        drive(1'b1, 4'd0, 5'd3, 32'd10, 32'd20);
        n = 0;
        while (bus.stall && n < 100) begin
            chk("mul_busy_wen", 32'(bus.wb_wen), 32'd0);
            n++;
            tick();
        end
        chk("mul_stall_len", 32'(n), 32'd32);
        chk("mul_wen", 32'(bus.wb_wen), 32'd1);
        chk("mul_waddr", 32'(bus.wb_waddr), 32'd8);
        chk("mul_wdata", bus.wb_wdata, 32'd35);
        tick();
        chk("held_add", bus.wb_wdata, 32'd30);
        chk("held_add_wen", 32'(bus.wb_wen), 32'd1);
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("held_add_once", 32'(bus.wb_wen), 32'd0);

        // MUL by zero still takes the full latency
        drive(1'b1, 4'd8, 5'd11, 32'hDEAD_BEEF, 32'd0);
        tick();
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            tick();
        end
        chk("mul0_len", 32'(n), 32'd32);
        chk("mul0_wdata", bus.wb_wdata, 32'd0);

        // Reset in the middle of a MUL
        drive(1'b1, 4'd8, 5'd12, 32'd3, 32'd3);
        tick();
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_stall", 32'(bus.stall), 32'd0);
        wcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.wb_wen) wcnt++;
        end
        chk("rst_mid_nowrite", 32'(wcnt), 32'd0);

        // Back-to-back dependence on the held result
        drive(1'b1, 4'd0, 5'd4, 32'd5, 32'd2);
`ifdef EX_BYPASS_EN
        bus.in_rs1 = 5'd1;
        bus.in_rs2 = 5'd2;
`endif
        tick();
        drive(1'b1, 4'd0, 5'd5, 32'd0, 32'd1);
`ifdef EX_BYPASS_EN
        bus.in_rs1 = 5'd4;
        bus.in_rs2 = 5'd0;
`endif
        tick();
`ifdef EX_BYPASS_EN
        chk("bypass_wdata", bus.wb_wdata, 32'd8);
`else
        chk("bypass_wdata", bus.wb_wdata, 32'd1);
`endif

        // Random traffic, including stimulus changes during stalls
        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            if (op == 4'd8 && $urandom_range(0, 3) != 0) op = 4'd0;
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(0, 40));
                default: ;
            endcase
            drive(1'($urandom_range(0, 3) != 0), op,
                  5'($urandom_range(0, 7)), a, b);
`ifdef EX_BYPASS_EN
            bus.in_rs1 = 5'($urandom_range(0, 7));
            bus.in_rs2 = 5'($urandom_range(0, 7));
`endif
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        for (int i = 0; i < 40; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
Execute stage of the four-stage pipeline. It sits between operand read and the register file write port. It accepts one decoded instruction per cycle with operands already read, computes the ALU result, and registers wen/waddr/wdata for the register file write port. MUL runs as a multi-cycle shift-add operation and stalls upstream while busy.

Parameters:
DSIZE, 32, datapath width in bits.
ASIZE, 5, register address width.
SHW, 5, shift-amount width; equals clog2(DSIZE).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  instruction present on the in_* buses.
in_op  input  4  opcode (encoding below).
in_rd  input  ASIZE  destination register.
in_a  input  DSIZE  operand A.
in_b  input  DSIZE  operand B (register value or immediate, selected upstream).
stall  output  1  stage busy; upstream holds its instruction while high.
wb_wen  output  1  register file write enable.
wb_waddr  output  ASIZE  register file write address.
wb_wdata  output  DSIZE  register file write data.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, stall=0, wb_wen=0, wb_waddr=0, wb_wdata=0, multiplier registers cleared. Reset overrides every other event, including a MUL in progress, which is discarded with no write.
- Accept: an instruction is accepted at an edge when in_valid=1 and stall=0. While stall=1, the in_* inputs are ignored.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL (logical), 7 SLT (signed compare, result 1 or 0), 8 MUL (low DSIZE bits of the product), 9 NOP. Opcodes 10-15 are treated as NOP.
- Arithmetic: ADD and SUB wrap modulo 2^DSIZE; there is no overflow flag. Shift amount = in_b[SHW-1:0].
- Single-cycle ops: at the accept edge, wb_wen=1, wb_waddr=in_rd, wb_wdata=result. wb_wen is high for exactly one cycle per instruction unless another instruction is accepted at the next edge.
- NOP or unknown opcode: at the accept edge, wb_wen=0; wb_waddr and wb_wdata hold their previous values.
- No accept at an edge (in_valid=0, or busy): wb_wen=0 at that edge.
- A write to any register address, including 0, is issued as-is; this stage applies no r0 suppression.
- FSM states: IDLE and MUL_BUSY. stall = (state==MUL_BUSY), driven from a register.
- IDLE to MUL_BUSY: on accepting opcode 8. At that edge: latch multiplicand=in_a, multiplier=in_b, rd=in_rd; acc=0; cnt=0; wb_wen=0.
- MUL_BUSY, one step per edge: if multiplier[0]=1, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++.
- MUL_BUSY to IDLE: on the edge where cnt==DSIZE-1 (the DSIZE-th step). At that edge: wb_wen=1, wb_waddr=latched rd, wb_wdata=final acc, stall falls to 0.
- MUL timing: accept at edge T0, stall=1 during cycles T0..T0+DSIZE-1, result written at edge T0+DSIZE. The next instruction can be accepted at edge T0+DSIZE+1.
- MUL operand boundaries: in_b=0 gives result 0 after the full DSIZE cycles; there is no early exit.

Optional Feature:
Macro EX_BYPASS_EN.
- Defined: adds input ports in_rs1 (ASIZE) and in_rs2 (ASIZE), the source register addresses of in_a and in_b. At accept, if wb_wen=1 and wb_waddr==in_rs1, operand A = wb_wdata instead of in_a; same rule for in_rs2 and operand B. This resolves back-to-back dependences on the value still held in the stage output register.
- Not defined: the ports are absent and in_a/in_b are used unmodified.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 -> stall=0, wb_wen=0, wb_waddr=0, wb_wdata=0 on every cycle.
- ADD/SUB/SLT: ADD a=5 b=2 rd=4 -> next edge wb_wen=1, waddr=4, wdata=7. SUB a=2 b=5 rd=6 -> wdata=0xFFFFFFFD. SLT a=0xFFFFFFFD b=2 -> wdata=1.
- Shifts: SLL a=1 b=0x21 -> wdata=2 (amount=1). SRL a=0x80000000 b=31 -> wdata=1.
- MUL: a=5 b=7 rd=8 at T0 -> stall=1 for exactly 32 cycles, wb_wen=0 throughout, then wdata=35 waddr=8 at edge T0+32. An ADD held on in_valid during the stall is accepted only after stall drops, and is written exactly once.
- Reset mid-MUL: assert rst at T0+10 -> no write ever appears; stall=0 the cycle after reset.
- EX_BYPASS_EN: ADD r4=5+2, then back-to-back ADD rs1=4 with stale in_a=0, b=1 -> wdata=8. Without the macro, the same stimulus gives wdata=1.
